// File: rtl/riscv_pkg.sv
// Shared RV32IM definitions: opcodes, ALUOp encodings and the decoder control bundle
// that travels through the ID/EX and EX/MEM pipeline registers.
package riscv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // What the ID/EX register does on the next edge, highest priority first.
    typedef enum logic [1:0] {
        ACT_FLUSH  = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_LOAD   = 2'd3
    } action_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: the instruction in ID reads a register that the load
// currently in EX has not produced yet.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_to_reg,
    input  logic [4:0] ex_rd,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OPC_R, OPC_STORE, OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_I_ALU, OPC_LOAD: begin
                uses_rs1 = 1'b1;
            end
            default: begin
            end
        endcase

        rs1_match = uses_rs1 && (ex_rd == id_rs1);
        rs2_match = uses_rs2 && (ex_rd == id_rs2);
        // x0 is never a real destination, so a load to x0 cannot create a hazard.
        load_use  = ex_valid && ex_mem_to_reg && (ex_rd != 5'd0) && id_valid
                    && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold/bubble control and saturating
// performance counters for the five-stage RV32IM core.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic [6:0]       id_funct7,
    input  logic             id_RegWrite,
    input  logic             id_MemWrite,
    input  logic             id_MemtoReg,
    input  logic             id_Branch,
    input  logic             id_Jump,
    input  logic             id_ALUSrc,
    input  logic [1:0]       id_ALUOp,
    input  logic             ex_flush,
    input  logic             ex_busy,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic             ex_RegWrite,
    output logic             ex_MemWrite,
    output logic             ex_MemtoReg,
    output logic             ex_Branch,
    output logic             ex_Jump,
    output logic             ex_ALUSrc,
    output logic [1:0]       ex_ALUOp,
    output logic             stall_if_id,
    output logic [CNT_W-1:0] cnt_cycles,
    output logic [CNT_W-1:0] cnt_issued,
    output logic [CNT_W-1:0] cnt_bubbles,
    output logic [CNT_W-1:0] cnt_flushes,
    output logic [CNT_W-1:0] cnt_holds
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            valid_q, valid_d;
    ctrl_t           ctrl_q, ctrl_d;
    ctrl_t           id_ctrl;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [6:0]      funct7_q, funct7_d;

    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] bubbles_q, bubbles_d;
    logic [CNT_W-1:0] flushes_q, flushes_d;
    logic [CNT_W-1:0] holds_q, holds_d;

    logic    uses_rs1;
    logic    uses_rs2;
    logic    load_use;
    action_e action;

    hazard_detect u_hazard_detect (
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_valid      (valid_q),
        .ex_mem_to_reg (ctrl_q.mem_to_reg),
        .ex_rd         (rd_q),
        .uses_rs1      (uses_rs1),
        .uses_rs2      (uses_rs2),
        .load_use      (load_use)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        id_ctrl.reg_write  = id_RegWrite;
        id_ctrl.mem_write  = id_MemWrite;
        id_ctrl.mem_to_reg = id_MemtoReg;
        id_ctrl.branch     = id_Branch;
        id_ctrl.jump       = id_Jump;
        id_ctrl.alu_src    = id_ALUSrc;
        id_ctrl.alu_op     = id_ALUOp;

        if (ex_flush) begin
            action = ACT_FLUSH;
        end else if (ex_busy) begin
            action = ACT_HOLD;
        end else if (load_use) begin
            action = ACT_BUBBLE;
        end else begin
            action = ACT_LOAD;
        end

        // A redirect replaces IF/ID, so a flush never stalls even if a hazard is visible.
        stall_if_id = !ex_flush && (ex_busy || load_use);
    end

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;

        case (action)
            ACT_FLUSH, ACT_BUBBLE: begin
                // Zeroed controls keep a killed slot from writing registers or memory.
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            ACT_LOAD: begin
                valid_d    = id_valid;
                ctrl_d     = id_valid ? id_ctrl : '0;
                pc_d       = id_pc;
                rs1_data_d = id_rs1_data;
                rs2_data_d = id_rs2_data;
                imm_d      = id_imm;
                rs1_d      = id_rs1;
                rs2_d      = id_rs2;
                rd_d       = id_rd;
                funct3_d   = id_funct3;
                funct7_d   = id_funct7;
            end
            default: begin
            end
        endcase

        cycles_d  = sat_inc(cycles_q);
        issued_d  = (action == ACT_LOAD && id_valid) ? sat_inc(issued_q) : issued_q;
        bubbles_d = (action == ACT_BUBBLE) ? sat_inc(bubbles_q) : bubbles_q;
        flushes_d = (action == ACT_FLUSH)  ? sat_inc(flushes_q) : flushes_q;
        holds_d   = (action == ACT_HOLD)   ? sat_inc(holds_q)   : holds_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            cycles_q   <= '0;
            issued_q   <= '0;
            bubbles_q  <= '0;
            flushes_q  <= '0;
            holds_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            cycles_q   <= cycles_d;
            issued_q   <= issued_d;
            bubbles_q  <= bubbles_d;
            flushes_q  <= flushes_d;
            holds_q    <= holds_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7   = funct7_q;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_Jump     = ctrl_q.jump;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_ALUOp    = ctrl_q.alu_op;
    assign cnt_cycles  = cycles_q;
    assign cnt_issued  = issued_q;
    assign cnt_bubbles = bubbles_q;
    assign cnt_flushes = flushes_q;
    assign cnt_holds   = holds_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold/reset scenarios followed by
// random traffic, all checked against a rule-level model of the ID/EX register.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic            id_RegWrite, id_MemWrite, id_MemtoReg, id_Branch, id_Jump, id_ALUSrc;
  logic [1:0]      id_ALUOp;
  logic            ex_flush, ex_busy;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic            ex_RegWrite, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_Jump, ex_ALUSrc;
  logic [1:0]      ex_ALUOp;
  logic            stall_if_id;
  logic [31:0]     cnt_cycles, cnt_issued, cnt_bubbles, cnt_flushes, cnt_holds;

  // Narrow-counter copy used only to observe saturation.
  logic            s_valid;
  logic [XLEN-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]      s_rs1, s_rs2, s_rd;
  logic [2:0]      s_funct3;
  logic [6:0]      s_funct7;
  logic            s_RegWrite, s_MemWrite, s_MemtoReg, s_Branch, s_Jump, s_ALUSrc;
  logic [1:0]      s_ALUOp;
  logic            s_stall;
  logic [3:0]      s_cycles, s_issued, s_bubbles, s_flushes, s_holds;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg),
    .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .ex_flush(ex_flush), .ex_busy(ex_busy), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .stall_if_id(stall_if_id), .cnt_cycles(cnt_cycles), .cnt_issued(cnt_issued),
    .cnt_bubbles(cnt_bubbles), .cnt_flushes(cnt_flushes), .cnt_holds(cnt_holds)
  );

  id_ex_stage #(.XLEN(XLEN), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg),
    .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .ex_flush(ex_flush), .ex_busy(ex_busy), .ex_valid(s_valid),
    .ex_pc(s_pc), .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3), .ex_funct7(s_funct7),
    .ex_RegWrite(s_RegWrite), .ex_MemWrite(s_MemWrite), .ex_MemtoReg(s_MemtoReg),
    .ex_Branch(s_Branch), .ex_Jump(s_Jump), .ex_ALUSrc(s_ALUSrc), .ex_ALUOp(s_ALUOp),
    .stall_if_id(s_stall), .cnt_cycles(s_cycles), .cnt_issued(s_issued),
    .cnt_bubbles(s_bubbles), .cnt_flushes(s_flushes), .cnt_holds(s_holds)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what the EX slot should hold, plus counter totals.
  logic            m_valid;
  logic [7:0]      m_ctrl;
  logic            m_dp_known;
  logic [XLEN-1:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [2:0]      m_funct3;
  logic [6:0]      m_funct7;
  longint          m_cyc, m_iss, m_bub, m_flu, m_hld, m_sat_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint max);
    return (v >= max) ? max : v + 1;
  endfunction

  function automatic logic model_load_use();
    logic reads1, reads2, ex_is_load;
    reads1 = id_opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    reads2 = id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    ex_is_load = m_valid && m_ctrl[5] && (m_rd != 5'd0);
    return ex_is_load && id_valid && ((reads1 && m_rd == id_rs1) || (reads2 && m_rd == id_rs2));
  endfunction

  task automatic model_edge(input logic lu);
    if (!rst_n) begin
      m_valid = 0; m_ctrl = '0; m_dp_known = 1;
      m_pc = '0; m_rs1_data = '0; m_rs2_data = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_funct3 = '0; m_funct7 = '0;
      m_cyc = 0; m_iss = 0; m_bub = 0; m_flu = 0; m_hld = 0; m_sat_cyc = 0;
    end else begin
      m_cyc = sat(m_cyc, 64'hFFFF_FFFF);
      m_sat_cyc = sat(m_sat_cyc, 15);
      if (ex_flush) begin
        m_valid = 0; m_ctrl = '0; m_dp_known = 0;
        m_flu = sat(m_flu, 64'hFFFF_FFFF);
      end else if (ex_busy) begin
        m_hld = sat(m_hld, 64'hFFFF_FFFF);
      end else if (lu) begin
        m_valid = 0; m_ctrl = '0; m_dp_known = 0;
        m_bub = sat(m_bub, 64'hFFFF_FFFF);
      end else begin
        m_valid = id_valid;
        m_ctrl = id_valid ? {id_RegWrite, id_MemWrite, id_MemtoReg, id_Branch,
                             id_Jump, id_ALUSrc, id_ALUOp} : 8'h00;
        m_dp_known = 1;
        m_pc = id_pc; m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data; m_imm = id_imm;
        m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct3 = id_funct3; m_funct7 = id_funct7;
        if (id_valid) m_iss = sat(m_iss, 64'hFFFF_FFFF);
      end
    end
  endtask

  task automatic check_all();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_ctrl", {ex_RegWrite, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_Jump, ex_ALUSrc, ex_ALUOp}, m_ctrl);
    chk("cnt_cycles", cnt_cycles, m_cyc);
    chk("cnt_issued", cnt_issued, m_iss);
    chk("cnt_bubbles", cnt_bubbles, m_bub);
    chk("cnt_flushes", cnt_flushes, m_flu);
    chk("cnt_holds", cnt_holds, m_hld);
    chk("sat_cycles", s_cycles, m_sat_cyc);
    if (m_dp_known) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs1_data", ex_rs1_data, m_rs1_data);
      chk("ex_rs2_data", ex_rs2_data, m_rs2_data);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m_rs1, m_rs2, m_rd});
      chk("ex_funct", {ex_funct3, ex_funct7}, {m_funct3, m_funct7});
    end
  endtask

  // Inputs are driven at the falling edge; stall is checked before the rising edge.
  task automatic step();
    logic lu;
    #1;
    lu = model_load_use();
    chk("stall_if_id", stall_if_id, !ex_flush && (ex_busy || lu));
    @(posedge clk);
    model_edge(lu);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [6:0] f7);
    id_valid = 1'b1;
    id_opcode = opc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_funct7 = f7;
    id_funct3 = 3'($urandom_range(0, 7));
    id_pc = id_pc + 32'd4;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    {id_RegWrite, id_MemWrite, id_MemtoReg, id_Branch, id_Jump, id_ALUSrc, id_ALUOp} = 8'h00;
    case (opc)
      7'b0110011: begin id_RegWrite = 1; id_ALUOp = 2'b10; end
      7'b0010011: begin id_RegWrite = 1; id_ALUSrc = 1; id_ALUOp = 2'b10; end
      7'b0000011: begin id_RegWrite = 1; id_MemtoReg = 1; id_ALUSrc = 1; end
      7'b0100011: begin id_MemWrite = 1; id_ALUSrc = 1; end
      7'b1100011: begin id_Branch = 1; id_ALUOp = 2'b01; end
      7'b1101111: begin id_RegWrite = 1; id_Jump = 1; end
      default: ;
    endcase
  endtask

  initial begin
    logic [6:0] opcs [7];
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111};
    rst_n = 1'b0; ex_flush = 0; ex_busy = 0; id_pc = 32'h1000;
    drive(7'b0000011, 5'd3, 5'd4, 5'd5, 7'd0);
    m_valid = 0; m_ctrl = '0; m_rd = '0; m_dp_known = 0;
    m_cyc = 0; m_iss = 0; m_bub = 0; m_flu = 0; m_hld = 0; m_sat_cyc = 0;
    @(negedge clk);

    // Reset with live-looking ID inputs.
    step(); step();
    chk("reset_rd", ex_rd, 5'd0);
    chk("reset_cycles", cnt_cycles, 32'd0);

    // addi x1, x0, 5
    rst_n = 1'b1;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 7'd0); id_imm = 32'd5;
    step();
    chk("addi_valid", {ex_valid, ex_RegWrite, ex_ALUSrc}, 3'b111);
    chk("addi_rd", ex_rd, 5'd1);
    chk("addi_issued", cnt_issued, 32'd1);

    // lw x5, 0(x2) ; add x6, x5, x7 -> one bubble, then the add loads.
    drive(7'b0000011, 5'd5, 5'd2, 5'd0, 7'd0); step();
    drive(7'b0110011, 5'd6, 5'd5, 5'd7, 7'd0);
    #1 chk("lu_stall", stall_if_id, 1'b1);
    step();
    chk("lu_bubble", {ex_valid, ex_RegWrite}, 2'b00);
    chk("lu_bubbles", cnt_bubbles, 32'd1);
    step();
    chk("lu_add_loaded", {ex_valid, ex_rd}, {1'b1, 5'd6});

    // No false hazard: load to x0, JAL, addi with rs2 field matching.
    drive(7'b0000011, 5'd0, 5'd2, 5'd0, 7'd0); step();
    drive(7'b0110011, 5'd6, 5'd0, 5'd0, 7'd0);
    #1 chk("x0_no_stall", stall_if_id, 1'b0);
    step();
    drive(7'b0000011, 5'd5, 5'd2, 5'd0, 7'd0); step();
    drive(7'b1101111, 5'd1, 5'd5, 5'd5, 7'd0);
    #1 chk("jal_no_stall", stall_if_id, 1'b0);
    step();
    drive(7'b0000011, 5'd5, 5'd2, 5'd0, 7'd0); step();
    drive(7'b0010011, 5'd6, 5'd9, 5'd5, 7'd0);
    #1 chk("addi_rs2_no_stall", stall_if_id, 1'b0);
    step();

    // Flush with a valid sw in ID, then flush coinciding with a load-use hazard.
    drive(7'b0100011, 5'd0, 5'd3, 5'd4, 7'd0); ex_flush = 1; step(); ex_flush = 0;
    chk("flush_kill", {ex_valid, ex_MemWrite}, 2'b00);
    chk("flush_count", cnt_flushes, 32'd1);
    drive(7'b0000011, 5'd5, 5'd2, 5'd0, 7'd0); step();
    drive(7'b0100011, 5'd0, 5'd5, 5'd4, 7'd0); ex_flush = 1;
    #1 chk("flush_lu_stall", stall_if_id, 1'b0);
    step(); ex_flush = 0;

    // mul, then busy for 4 cycles with the next instruction waiting in ID.
    drive(7'b0110011, 5'd10, 5'd11, 5'd12, 7'd1); step();
    drive(7'b0010011, 5'd13, 5'd14, 5'd0, 7'd0); ex_busy = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("busy_frozen_rd", ex_rd, 5'd10);
    end
    ex_busy = 0;
    chk("busy_holds", cnt_holds, 32'd4);
    step();
    chk("busy_then_load", ex_rd, 5'd13);

    // Reset asserted in the middle of a hold.
    drive(7'b0110011, 5'd15, 5'd1, 5'd2, 7'd1); step();
    ex_busy = 1; step(); step();
    rst_n = 1'b0; step();
    chk("midhold_reset_valid", ex_valid, 1'b0);
    chk("midhold_reset_holds", cnt_holds, 32'd0);
    rst_n = 1'b1; ex_busy = 0;

    // 20 cycles out of reset: the 4-bit copy pins at 15.
    for (int i = 0; i < 20; i++) begin
      drive(opcs[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 7'd0);
      step();
    end
    chk("sat_pinned", s_cycles, 4'd15);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(opcs[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 7'($urandom_range(0, 1)));
      id_valid = ($urandom_range(0, 7) != 0);
      ex_flush = ($urandom_range(0, 7) == 0);
      ex_busy = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with load-use hazard detection, flush/hold control and pipeline performance counters for the five-stage RV32IM core. It sits directly after the main decoder and register file in ID and registers the decoder's control bundle, operands and register indices into EX. It inserts exactly one bubble on a load-use hazard, kills the EX slot on a taken branch or jump, and holds while the multi-cycle mul/div unit is busy. Its counters feed the performance-evaluation readout.

## Interface
- XLEN, 32, datapath width
- CNT_W, 32, performance counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  IF/ID slot holds a real instruction
- id_opcode  in  7  opcode of the ID instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN  ID datapath values
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct3  in  3; id_funct7  in  7  ALU decode fields
- id_RegWrite, id_MemWrite, id_MemtoReg, id_Branch, id_Jump, id_ALUSrc  in  1  decoder control outputs
- id_ALUOp  in  2  decoder ALUOp
- ex_flush  in  1  taken branch or jump resolved in EX
- ex_busy  in  1  mul/div unit in EX not finished
- ex_valid  out  1  EX slot holds a real instruction
- ex_* (pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7, all seven control signals)  out  matching widths  registered copies
- stall_if_id  out  1  hold PC and IF/ID this cycle
- cnt_cycles, cnt_issued, cnt_bubbles, cnt_flushes, cnt_holds  out  CNT_W each  performance counters

## Operation
- Operand use:
  - uses_rs1 = 1 for opcodes 0110011, 0010011, 0000011, 0100011 and 1100011; 0 otherwise, including JAL 1101111.
  - uses_rs2 = 1 for 0110011, 0100011 and 1100011.
- load_use = ex_valid & ex_MemtoReg & (ex_rd != 0) & id_valid & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- Next-state action, highest priority first:
  1. FLUSH (ex_flush = 1): ex_valid <= 0 and all seven control outputs <= 0. Datapath outputs are don't-care.
  2. HOLD (ex_busy = 1): all ex_* keep their values.
  3. BUBBLE (load_use = 1): ex_valid <= 0 and all control outputs <= 0. The ID instruction is not consumed.
  4. LOAD: all ex_* <= id_*, with ex_valid <= id_valid. When id_valid = 0, the control outputs are forced to 0.
- stall_if_id = ~ex_flush & (ex_busy | load_use), combinational. When ex_flush is asserted, IF/ID is redirected rather than stalled.
- A bubble never carries RegWrite or MemWrite. This is what makes a killed slot architecturally invisible.
- Counter updates, all saturating at 2^CNT_W - 1:
  - cnt_cycles increments every cycle out of reset.
  - cnt_issued increments on LOAD with id_valid = 1.
  - cnt_bubbles increments on BUBBLE.
  - cnt_flushes increments on FLUSH.
  - cnt_holds increments on HOLD.
  - Exactly one of the four action counters increments per cycle, except a LOAD with id_valid = 0, which counts only in cnt_cycles.

## Timing
- Reset (rst_n low at a rising edge): every ex_* output and every counter becomes 0. stall_if_id is 0 after the edge because ex_valid = 0.
- A reset asserted mid-hold or mid-bubble wins over every action.
- Latency: one cycle from the ID inputs to the ex_* outputs. The hazard path is combinational from the registered ex_* values and the current id_* inputs.
- A load-use hazard costs exactly one bubble cycle. The next cycle ex_MemtoReg = 0, so the held instruction loads, and the data is forwarded from MEM/WB.
- ex_busy held for N cycles produces N hold cycles with stall_if_id = 1. The instruction waiting in ID loads on the first cycle with ex_busy = 0, unless a hazard applies.
- ex_flush and ex_busy asserted together resolve as a flush.
- ex_flush and load_use asserted together resolve as a flush, with stall_if_id = 0.

## Structure
- The shared package riscv_pkg holds:
  - opcode constants (R, I-ALU, LOAD, STORE, BRANCH, JAL)
  - ALUOp encodings (00 add, 01 sub/compare, 10 funct-decoded)
  - a packed ctrl_t struct of the seven control signals, shared with the decoder and the EX/MEM register
- One sub-module, hazard_detect: purely combinational, produces uses_rs1, uses_rs2 and load_use.
- Counters live inline in id_ex_stage.

## Test plan
- Reset: drive rst_n = 0 with nonzero id_* inputs -> all ex_* and counters read 0. Release reset, present addi x1, x0, 5 -> ex_valid = 1, ex_RegWrite = 1, ex_ALUSrc = 1, ex_rd = 1 one cycle later, cnt_issued = 1.
- Load-use: lw x5, 0(x2) followed by add x6, x5, x7 -> one cycle with stall_if_id = 1 and a bubble (ex_valid = 0, ex_RegWrite = 0), then the add loads. cnt_bubbles = 1.
- No false hazard:
  - lw x0 followed by add x6, x0, x0 -> no stall.
  - lw x5 followed by jal x1 -> no stall, since JAL does not use rs1.
  - lw x5 followed by addi x6, x9, 1 with id_rs2 = 5 -> no stall, since addi does not use rs2.
- Flush: pulse ex_flush with a valid sw in ID -> the next cycle has ex_valid = 0 and ex_MemWrite = 0, and cnt_flushes increments. Repeat with load_use = 1 at the same time -> stall_if_id = 0.
- Busy: hold ex_busy for 4 cycles behind a mul -> ex_* stay frozen, stall_if_id = 1 for 4 cycles, cnt_holds = 4, then the ID instruction loads. Assert rst_n low mid-hold -> clean reset.
- Saturation: with CNT_W = 4, run 20 cycles -> cnt_cycles = 15 and stays at 15.
